sgdmac_axi_sram_slave: RTL

- AXI3-style slave memory that sits directly downstream of the SGDMAC master ports.
- Consumes the DMAC's AW/W/B and AR/R channels and services them from an internal word-addressed single-port SRAM.
- Serves as the backing store for descriptors, source data and destination data in SoC integration and block-level simulation.
- Handles one transaction at a time. Read and write requests are arbitrated round-robin.

---
 rtl/sgdmac_pkg.sv | 32 +++
 rtl/sgdmac_sram_sp.sv | 29 ++
 rtl/sgdmac_axi_sram_slave.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/sgdmac_pkg.sv
// sgdmac_pkg: AXI encodings, FSM state type and address helpers shared by the SGDMAC SRAM slave.
package sgdmac_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B     = 3'd2;

  typedef enum logic [1:0] {
    IDLE,
    WR_DATA,
    WR_RESP,
    RD_DATA
  } sgdmac_sram_state_t;

  // A request is illegal as a whole for a wrong size, reserved burst type or unaligned start.
  function automatic logic req_illegal(input logic [1:0] addr_lsb,
                                       input logic [2:0] size,
                                       input logic [1:0] burst);
    return (size != AXI_SIZE_4B) ||
           ((burst != AXI_BURST_FIXED) && (burst != AXI_BURST_INCR)) ||
           (addr_lsb != 2'b00);
  endfunction

  function automatic logic [31:0] beat_addr(input logic [31:0] start,
                                            input logic [1:0]  burst,
                                            input logic [3:0]  beat);
    return (burst == AXI_BURST_INCR) ? start + {26'd0, beat, 2'b00} : start;
  endfunction

endpackage

// File: rtl/sgdmac_sram_sp.sv
// sgdmac_sram_sp: single-port synchronous SRAM of 32-bit words with byte write enables.
// Read data is registered and holds until the next read access.
module sgdmac_sram_sp #(
  parameter int unsigned MEM_WORDS = 4096
) (
  input  logic                         clk,
  input  logic                         en,
  input  logic                         we,
  input  logic [3:0]                   be,
  input  logic [$clog2(MEM_WORDS)-1:0] addr,
  input  logic [31:0]                  wdata,
  output logic [31:0]                  rdata
);

  logic [31:0] mem [MEM_WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/sgdmac_axi_sram_slave.sv
// sgdmac_axi_sram_slave: AXI3-style slave servicing one read or write burst at a time from an SRAM.
// Define SGDMAC_SRAM_WSTRB_EN to honour wstrb_i; otherwise every beat writes the full word.
module sgdmac_axi_sram_slave
  import sgdmac_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned ID_W      = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [ID_W-1:0] awid_i,
  input  logic [31:0]     awaddr_i,
  input  logic [3:0]      awlen_i,
  input  logic [2:0]      awsize_i,
  input  logic [1:0]      awburst_i,
  input  logic            awvalid_i,
  output logic            awready_o,
  input  logic [ID_W-1:0] wid_i,
  input  logic [31:0]     wdata_i,
  input  logic [3:0]      wstrb_i,
  input  logic            wlast_i,
  input  logic            wvalid_i,
  output logic            wready_o,
  output logic [ID_W-1:0] bid_o,
  output logic [1:0]      bresp_o,
  output logic            bvalid_o,
  input  logic            bready_i,
  input  logic [ID_W-1:0] arid_i,
  input  logic [31:0]     araddr_i,
  input  logic [3:0]      arlen_i,
  input  logic [2:0]      arsize_i,
  input  logic [1:0]      arburst_i,
  input  logic            arvalid_i,
  output logic            arready_o,
  output logic [ID_W-1:0] rid_o,
  output logic [31:0]     rdata_o,
  output logic [1:0]      rresp_o,
  output logic            rlast_o,
  output logic            rvalid_o,
  input  logic            rready_i
);

  localparam int unsigned IDX_W = $clog2(MEM_WORDS);

  sgdmac_sram_state_t state;
  logic            last_wr_q;
  logic [ID_W-1:0] id_q;
  logic [31:0]     addr_q;
  logic [3:0]      len_q;
  logic [1:0]      burst_q;
  logic [3:0]      beat_cnt;
  logic            hdr_err_q;
  logic            err_q;
  logic            rerr_q;

  logic        aw_hs, ar_hs, r_adv, wr_en, beat_is_last;
  logic [31:0] mem_addr, mem_word;
  logic        mem_in_range;
  logic [3:0]  sram_be;
  logic [31:0] sram_rdata;
  logic        unused_ok;

  // Round-robin: a lone request is always granted; on contention the side not served last wins.
  assign awready_o = rst_n && (state == IDLE) && awvalid_i && (!arvalid_i || !last_wr_q);
  assign arready_o = rst_n && (state == IDLE) && arvalid_i && (!awvalid_i || last_wr_q);
  assign aw_hs     = awready_o && awvalid_i;
  assign ar_hs     = arready_o && arvalid_i;

  assign beat_is_last = (beat_cnt == len_q);
  assign wready_o     = (state == WR_DATA);
  assign bvalid_o     = (state == WR_RESP);
  assign bid_o        = id_q;
  assign bresp_o      = (bvalid_o && err_q) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
  assign rvalid_o     = (state == RD_DATA);
  assign rid_o        = id_q;
  assign rlast_o      = rvalid_o && beat_is_last;
  assign rresp_o      = (rvalid_o && rerr_q) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
  assign rdata_o      = (rvalid_o && !rerr_q) ? sram_rdata : 32'h0;

  // The SRAM address always points at the beat being written, or at the beat to prefetch for R.
  always_comb begin
    mem_addr = addr_q;
    case (state)
      IDLE:    mem_addr = araddr_i;
      WR_DATA: mem_addr = beat_addr(addr_q, burst_q, beat_cnt);
      RD_DATA: mem_addr = beat_addr(addr_q, burst_q, beat_cnt + 4'd1);
      default: mem_addr = addr_q;
    endcase
  end

  assign mem_word     = (mem_addr - BASE_ADDR) >> 2;
  assign mem_in_range = (mem_word < MEM_WORDS);
  assign r_adv        = rvalid_o && rready_i && !beat_is_last;
  assign wr_en        = (state == WR_DATA) && wvalid_i && !hdr_err_q && mem_in_range;

`ifdef SGDMAC_SRAM_WSTRB_EN
  assign sram_be   = wstrb_i;
  assign unused_ok = ^wid_i;
`else
  assign sram_be   = 4'hF;
  assign unused_ok = ^{wid_i, wstrb_i};
`endif

  sgdmac_sram_sp #(
    .MEM_WORDS (MEM_WORDS)
  ) u_sram (
    .clk   (clk),
    .en    (ar_hs || r_adv || wr_en),
    .we    (wr_en),
    .be    (sram_be),
    .addr  (mem_word[IDX_W-1:0]),
    .wdata (wdata_i),
    .rdata (sram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last_wr_q <= 1'b0;
      id_q      <= '0;
      addr_q    <= 32'h0;
      len_q     <= 4'd0;
      burst_q   <= AXI_BURST_FIXED;
      beat_cnt  <= 4'd0;
      hdr_err_q <= 1'b0;
      err_q     <= 1'b0;
      rerr_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (aw_hs) begin
            id_q      <= awid_i;
            addr_q    <= awaddr_i;
            len_q     <= awlen_i;
            burst_q   <= awburst_i;
            beat_cnt  <= 4'd0;
            hdr_err_q <= req_illegal(awaddr_i[1:0], awsize_i, awburst_i);
            err_q     <= req_illegal(awaddr_i[1:0], awsize_i, awburst_i);
            last_wr_q <= 1'b1;
            state     <= WR_DATA;
          end else if (ar_hs) begin
            id_q      <= arid_i;
            addr_q    <= araddr_i;
            len_q     <= arlen_i;
            burst_q   <= arburst_i;
            beat_cnt  <= 4'd0;
            hdr_err_q <= req_illegal(araddr_i[1:0], arsize_i, arburst_i);
            rerr_q    <= req_illegal(araddr_i[1:0], arsize_i, arburst_i) || !mem_in_range;
            last_wr_q <= 1'b0;
            state     <= RD_DATA;
          end
        end
        WR_DATA: begin
          if (wvalid_i) begin
            beat_cnt <= beat_cnt + 4'd1;
            if (!mem_in_range || (wlast_i != beat_is_last)) err_q <= 1'b1;
            if (wlast_i || beat_is_last) state <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (bready_i) state <= IDLE;
        end
        RD_DATA: begin
          if (rready_i) begin
            if (beat_is_last) begin
              state <= IDLE;
            end else begin
              beat_cnt <= beat_cnt + 4'd1;
              rerr_q   <= hdr_err_q || !mem_in_range;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
